// File: rtl/dmem_responder.sv
// dmem_responder: latency-modelling byte-addressable data memory for the
// core's data port. One request is accepted at a time, and a single-cycle
// response strobe follows LATENCY cycles after acceptance.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to add the op_error port.
// With it, out-of-range writes are dropped and out-of-range reads return zero.
// Without it, out-of-range addresses alias onto the index bits.
//
// Handshake: a request (ip_data_rd | ip_data_wr) is taken on a rising edge
// where op_ready is high. The requester holds the request until it sees
// op_ready, and requests presented while op_ready is low are ignored.
// op_data_valid is high for exactly one cycle per accepted request, for both
// reads and writes.
module dmem_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned LATENCY    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ip_data_addr,
   input  logic        ip_data_rd,
   input  logic        ip_data_wr,
   input  logic [3:0]  ip_data_mask,
   input  logic [31:0] ip_data_from_proc,
   output logic        op_ready,
   output logic        op_data_valid,
   output logic [31:0] op_data_to_proc,
`ifdef DMEM_BOUNDS_CHECK_EN
   output logic        op_error,
`endif
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   // Wait-counter preload. It is only used when LATENCY > 1.
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   logic [31:0]           mem [DEPTH];
   state_t                state;
   logic [3:0]            cnt;
   logic [31:0]           rd_q;
   logic                  is_rd_q;
   logic [31:0]           off;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           rd_word;
   logic                  accept;
   logic                  mem_we;
   logic [1:0]            unused_off_lsbs;

   assign off             = ip_data_addr - BASE_ADDR;
   assign idx             = off[DEPTH_LOG2+1:2];
   assign unused_off_lsbs = off[1:0];
   assign accept          = (state == S_IDLE) && (ip_data_rd || ip_data_wr);
   assign dbg_state       = state;

`ifdef DMEM_BOUNDS_CHECK_EN
   logic in_range;
   logic err_q;
   assign in_range = (off[31:DEPTH_LOG2+2] == '0);
   assign rd_word  = in_range ? mem[idx] : 32'h0000_0000;
   assign mem_we   = accept && ip_data_wr && in_range;
`else
   assign rd_word  = mem[idx];
   assign mem_we   = accept && ip_data_wr;
`endif

   // Byte-masked write commit at the accepting edge. Contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (ip_data_mask[i]) mem[idx][8*i +: 8] <= ip_data_from_proc[8*i +: 8];
         end
      end
   end

   // Request FSM: accept, count wait cycles, raise a one-cycle response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         cnt             <= 4'd0;
         rd_q            <= 32'h0000_0000;
         is_rd_q         <= 1'b0;
         op_ready        <= 1'b1;
         op_data_valid   <= 1'b0;
         op_data_to_proc <= 32'h0000_0000;
`ifdef DMEM_BOUNDS_CHECK_EN
         err_q           <= 1'b0;
         op_error        <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  // A write wins when both request lines are high.
                  is_rd_q  <= !ip_data_wr;
                  rd_q     <= rd_word;
                  op_ready <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
                  err_q    <= !in_range;
`endif
                  if (LATENCY == 1) begin
                     state         <= S_RESP;
                     op_data_valid <= 1'b1;
                     if (!ip_data_wr) op_data_to_proc <= rd_word;
`ifdef DMEM_BOUNDS_CHECK_EN
                     op_error      <= !in_range;
`endif
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state         <= S_RESP;
                  op_data_valid <= 1'b1;
                  if (is_rd_q) op_data_to_proc <= rd_q;
`ifdef DMEM_BOUNDS_CHECK_EN
                  op_error      <= err_q;
`endif
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state         <= S_IDLE;
               op_ready      <= 1'b1;
               op_data_valid <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
               op_error      <= 1'b0;
`endif
            end
            default: begin
               state         <= S_IDLE;
               op_ready      <= 1'b1;
               op_data_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Four instances with different LATENCY and
// DEPTH_LOG2 values share one clock. Each has its own reset and request lines.
module tb_dmem_responder;

   logic             clk;
   logic [3:0]       rst;
   logic [3:0][31:0] addr;
   logic [3:0]       rd;
   logic [3:0]       wr;
   logic [3:0][3:0]  mask;
   logic [3:0][31:0] wdata;
   logic [3:0]       rdy;
   logic [3:0]       vld;
   logic [3:0][31:0] dout;
   logic [3:0][1:0]  dbg;
`ifdef DMEM_BOUNDS_CHECK_EN
   logic [3:0]       err;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: LATENCY=1, 1: LATENCY=4, 2: LATENCY=3, 3: DEPTH_LOG2=4 with LATENCY=2.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_LOG2 ((g == 3) ? 4 : 10),
         .BASE_ADDR  (32'h0000_0000),
         .LATENCY    ((g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 3 : 2)
      ) u_dut (
         .clk               (clk),
         .reset             (rst[g]),
         .ip_data_addr      (addr[g]),
         .ip_data_rd        (rd[g]),
         .ip_data_wr        (wr[g]),
         .ip_data_mask      (mask[g]),
         .ip_data_from_proc (wdata[g]),
         .op_ready          (rdy[g]),
         .op_data_valid     (vld[g]),
         .op_data_to_proc   (dout[g]),
`ifdef DMEM_BOUNDS_CHECK_EN
         .op_error          (err[g]),
`endif
         .dbg_state         (dbg[g])
      );
   end

   function automatic int lat_of(input int s);
      case (s)
         0: return 1;
         1: return 4;
         2: return 3;
         default: return 2;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // Wait at negedges for op_ready, bounded. Called at a negedge.
   task automatic wait_ready(input int s, input string tag);
      int n;
      n = 0;
      while (rdy[s] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (rdy[s] !== 1'b1) check({tag, " ready_timeout"}, 32'(rdy[s]), 32'd1);
   endtask

   // One full request. The request is held until the response is seen. Then it
   // checks latency, the ready-low span, data out, error flag and the return to idle.
   task automatic do_req(input int s, input logic rd_i, input logic wr_i,
                         input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                         input logic [31:0] exp_data, input logic exp_err, input string tag);
      int n;
      int low;
      bit got;
      wait_ready(s, tag);
      rd[s] = rd_i; wr[s] = wr_i; addr[s] = a; mask[s] = m; wdata[s] = d;
      @(posedge clk);
      n = 0; low = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (rdy[s] === 1'b0) low++;
         if (vld[s] === 1'b1) got = 1;
      end
      check({tag, " latency"}, 32'(n), 32'(lat_of(s)));
      check({tag, " ready_low"}, 32'(low), 32'(lat_of(s)));
      check({tag, " data"}, dout[s], exp_data);
`ifdef DMEM_BOUNDS_CHECK_EN
      check({tag, " error"}, 32'(err[s]), 32'(exp_err));
`else
      if (exp_err) $display("note: %s expects error only with bounds check", tag);
`endif
      rd[s] = 1'b0; wr[s] = 1'b0;
      @(negedge clk);
      check({tag, " ready_back"}, 32'(rdy[s]), 32'd1);
      check({tag, " valid_drop"}, 32'(vld[s]), 32'd0);
   endtask

   // A request is accepted, then reset is pulsed for one cycle.
   // The pending response must never appear.
   task automatic req_then_reset(input int s, input logic rd_i, input logic wr_i,
                                 input logic [31:0] a, input logic [31:0] d, input string tag);
      bit seen;
      wait_ready(s, tag);
      rd[s] = rd_i; wr[s] = wr_i; addr[s] = a; mask[s] = 4'hF; wdata[s] = d;
      @(posedge clk);
      @(negedge clk);
      check({tag, " accepted"}, 32'(rdy[s]), 32'd0);
      rd[s] = 1'b0; wr[s] = 1'b0; rst[s] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst[s] = 1'b0;
      check({tag, " ready_after_rst"}, 32'(rdy[s]), 32'd1);
      check({tag, " valid_after_rst"}, 32'(vld[s]), 32'd0);
      check({tag, " data_after_rst"}, dout[s], 32'h0);
      check({tag, " state_after_rst"}, 32'(dbg[s]), 32'd0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (vld[s] === 1'b1) seen = 1;
      end
      check({tag, " no_late_valid"}, 32'(seen), 32'd0);
   endtask

   // directed stimulus
   initial begin
      rst = 4'hF; rd = '0; wr = '0; addr = '0; mask = '0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 4'h0;
      for (int s = 0; s < 4; s++) begin
         check($sformatf("rst%0d ready", s), 32'(rdy[s]), 32'd1);
         check($sformatf("rst%0d valid", s), 32'(vld[s]), 32'd0);
         check($sformatf("rst%0d data", s), dout[s], 32'h0);
         check($sformatf("rst%0d state", s), 32'(dbg[s]), 32'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
         check($sformatf("rst%0d error", s), 32'(err[s]), 32'd0);
`endif
      end

      // LATENCY=1: full write, then read it back.
      do_req(0, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0000_0000, 0, "l1_wr10");
      do_req(0, 1, 0, 32'h10, 4'h0, 32'h0,        32'hDEADBEEF, 0, "l1_rd10");
      // Partial mask: lanes 3 and 0 only.
      do_req(0, 0, 1, 32'h0C, 4'hF, 32'hFFFFFFFF, 32'hDEADBEEF, 0, "l1_wr0c");
      do_req(0, 0, 1, 32'h0C, 4'h9, 32'h12000034, 32'hDEADBEEF, 0, "l1_wr0c_m9");
      do_req(0, 1, 0, 32'h0C, 4'h0, 32'h0,        32'h12FFFF34, 0, "l1_rd0c");
      // Both rd and wr high: it is a write, so data out holds its value.
      do_req(0, 1, 1, 32'h30, 4'hF, 32'h5A5A5A5A, 32'h12FFFF34, 0, "l1_rdwr30");
      do_req(0, 1, 0, 32'h30, 4'h0, 32'h0,        32'h5A5A5A5A, 0, "l1_rd30");
      // Zero mask changes nothing but is acknowledged.
      do_req(0, 0, 1, 32'h08, 4'hF, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, "l1_wr08");
      do_req(0, 0, 1, 32'h08, 4'h0, 32'hFFFFFFFF, 32'h5A5A5A5A, 0, "l1_wr08_m0");
      do_req(0, 1, 0, 32'h08, 4'h0, 32'h0,        32'hA5A5A5A5, 0, "l1_rd08");

      // LATENCY=4: single-lane update of a full word.
      do_req(1, 0, 1, 32'h20, 4'hF, 32'h11223344, 32'h0000_0000, 0, "l4_wr20");
      do_req(1, 0, 1, 32'h20, 4'h4, 32'h00AB0000, 32'h0000_0000, 0, "l4_wr20_m4");
      do_req(1, 1, 0, 32'h20, 4'h0, 32'h0,        32'h11AB3344, 0, "l4_rd20");

      // LATENCY=3: reset mid-transaction drops the response.
      do_req(2, 0, 1, 32'h00, 4'hF, 32'hCAFEF00D, 32'h0000_0000, 0, "l3_wr00");
      do_req(2, 1, 0, 32'h00, 4'h0, 32'h0,        32'hCAFEF00D, 0, "l3_rd00");
      req_then_reset(2, 1, 0, 32'h00, 32'h0, "l3_rd_rst");
      req_then_reset(2, 0, 1, 32'h04, 32'h12345678, "l3_wr_rst");
      do_req(2, 1, 0, 32'h04, 4'h0, 32'h0,        32'h12345678, 0, "l3_rd04");

      // DEPTH_LOG2=4 (64 bytes): address 0x40 is out of range.
      do_req(3, 0, 1, 32'h00, 4'hF, 32'h11111111, 32'h0000_0000, 0, "d4_wr00");
`ifdef DMEM_BOUNDS_CHECK_EN
      do_req(3, 0, 1, 32'h40, 4'hF, 32'h00000077, 32'h0000_0000, 1, "d4_wr40");
      do_req(3, 1, 0, 32'h00, 4'h0, 32'h0,        32'h11111111, 0, "d4_rd00");
      do_req(3, 1, 0, 32'h40, 4'h0, 32'h0,        32'h00000000, 1, "d4_rd40");
`else
      do_req(3, 0, 1, 32'h40, 4'hF, 32'h00000077, 32'h0000_0000, 0, "d4_wr40");
      do_req(3, 1, 0, 32'h00, 4'h0, 32'h0,        32'h00000077, 0, "d4_rd00");
      do_req(3, 1, 0, 32'h40, 4'h0, 32'h0,        32'h00000077, 0, "d4_rd40");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
